// File: rtl/hanoivm_dispatch.sv
// Instruction dispatcher for the HanoiVM interpreter core: fetches 89-bit words
// from program memory, offers them to the core, and tracks completion and status.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start; status flags clear
// FETCH     | prog_rd_en high for this one cycle, prog_addr = pc
// WAIT_MEM  | prog_data valid; latch it, HALT opcode ends the program here
// ISSUE     | valid_out high until the core takes the instruction
// WAIT_DONE | instruction in flight, waiting for core_done
// ADVANCE   | pc+1, then next FETCH or HALT at prog_len
// HALT      | program finished; outputs held, start restarts
// ERROR     | core timed out; outputs held, start restarts
module hanoivm_dispatch #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [PC_W-1:0] prog_len,
  output logic [PC_W-1:0] prog_addr,
  output logic            prog_rd_en,
  input  logic [88:0]     prog_data,
  output logic [7:0]      opcode_out,
  output logic [80:0]     operand_out,
  output logic            valid_out,
  input  logic            core_ready,
  input  logic            core_done,
  input  logic [80:0]     core_result,
  output logic [80:0]     last_result,
  output logic [PC_W-1:0] retired,
  output logic            busy,
  output logic            halted,
  output logic            error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_WAIT_DONE,
    S_ADVANCE,
    S_HALT,
    S_ERROR
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [TW-1:0]   tmo_cnt;
  logic [PC_W:0]   pc_inc;
  logic            tmo_hit;
  logic            at_end;

  // pc_inc carries one extra bit so the end-of-program compare cannot wrap
  assign pc_inc    = {1'b0, pc} + (PC_W + 1)'(1);
  assign at_end    = (pc_inc >= {1'b0, prog_len});
  assign tmo_hit   = (tmo_cnt >= TMO_LAST);
  assign prog_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      tmo_cnt     <= '0;
      retired     <= '0;
      opcode_out  <= '0;
      operand_out <= '0;
      last_result <= '0;
      valid_out   <= 1'b0;
      prog_rd_en  <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      valid_out  <= 1'b0;
      prog_rd_en <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            pc          <= '0;
            retired     <= '0;
            last_result <= '0;
            error       <= 1'b0;
            if (prog_len == '0) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state      <= S_FETCH;
              prog_rd_en <= 1'b1;
              busy       <= 1'b1;
              halted     <= 1'b0;
            end
          end
        end

        S_FETCH: begin
          prog_rd_en <= 1'b0;
          state      <= S_WAIT_MEM;
        end

        S_WAIT_MEM: begin
          opcode_out  <= prog_data[88:81];
          operand_out <= prog_data[80:0];
          if (prog_data[88:81] == OP_HALT) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state     <= S_ISSUE;
            valid_out <= 1'b1;
            tmo_cnt   <= '0;
          end
        end

        // A transfer or completion on the final timeout cycle still counts.
        S_ISSUE: begin
          if (valid_out && core_ready) begin
            valid_out <= 1'b0;
            tmo_cnt   <= tmo_cnt + TW'(1);
            state     <= S_WAIT_DONE;
          end else if (tmo_hit) begin
            valid_out <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            state     <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_WAIT_DONE: begin
          if (core_done) begin
            last_result <= core_result;
            retired     <= retired + PC_W'(1);
            state       <= S_ADVANCE;
          end else if (tmo_hit) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_ADVANCE: begin
          pc <= pc_inc[PC_W] ? pc : pc_inc[PC_W-1:0];
          if (at_end) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state      <= S_FETCH;
            prog_rd_en <= 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          valid_out  <= 1'b0;
          prog_rd_en <= 1'b0;
          busy       <= 1'b0;
          halted     <= 1'b0;
          error      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hanoivm_dispatch.sv
// Bench for hanoivm_dispatch: program memory and core models, directed vector
// table, timeout/abort/reset sequences, and randomized programs vs a run model.
`timescale 1ns/1ps
module tb_hanoivm_dispatch;

  localparam int PC_W    = 8;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [PC_W-1:0] prog_len, prog_addr, retired;
  logic            prog_rd_en, valid_out, busy, halted, error;
  logic [88:0]     prog_data = '0;
  logic [7:0]      opcode_out;
  logic [80:0]     operand_out, last_result;
  logic            core_ready = 1'b1;
  logic            core_done  = 1'b0;
  logic [80:0]     core_result = '0;

  always #5 clk = ~clk;

  hanoivm_dispatch #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .prog_len(prog_len), .prog_addr(prog_addr), .prog_rd_en(prog_rd_en),
    .prog_data(prog_data), .opcode_out(opcode_out), .operand_out(operand_out),
    .valid_out(valid_out), .core_ready(core_ready), .core_done(core_done),
    .core_result(core_result), .last_result(last_result), .retired(retired),
    .busy(busy), .halted(halted), .error(error)
  );

  int errors = 0;
  int checks = 0;

  // stimulus controls, written only by the main initial block
  int          lat = 3;
  int          rdy_mode = 0;
  int          stall_init = 0;
  bit          clr_req = 1'b1;
  logic [88:0] mem [256];
  logic [80:0] core_res [256];

  // model state, written only by the negedge model block
  int          done_cnt = 0, done_idx = 0, stall_left = 0, rd_count = 0, mon_viol = 0;
  bit          hold = 1'b0, done_with_abort = 1'b0;
  logic [88:0] xfer_q [$];
  bit          prev_valid = 1'b0, prev_xfer = 1'b0, prev_abort = 1'b0, prev_rst = 1'b0;
  logic [88:0] prev_word = '0;
  logic [95:0] rnd;

  typedef struct {
    int          len, lat, mode, stall;
    logic [88:0] w [4];
    logic [80:0] r [4];
    int          exp_ret;
    logic [80:0] exp_last;
    int          exp_cyc, exp_rd;
  } vec_t;

  function automatic logic [88:0] wd(input logic [7:0] op, input logic [80:0] opd);
    return {op, opd};
  endfunction

  function automatic vec_t mk(input int len, input int l, input int mode, input int stall,
                              input logic [88:0] w0, w1, w2, w3,
                              input logic [80:0] r0, r1, r2, r3,
                              input int ret, input logic [80:0] last, input int cyc, input int rd);
    vec_t v;
    v.len = len; v.lat = l; v.mode = mode; v.stall = stall;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
    v.exp_ret = ret; v.exp_last = last; v.exp_cyc = cyc; v.exp_rd = rd;
    return v;
  endfunction

  // Core, memory and interface monitor; drives inputs on the falling edge.
  always @(negedge clk) begin
    bit xfer;
    if (clr_req) begin
      done_cnt = 0; done_idx = 0; stall_left = stall_init; rd_count = 0; mon_viol = 0;
      xfer_q.delete(); prev_valid = 1'b0; prev_xfer = 1'b0; done_with_abort = 1'b0;
    end
    if (prev_valid && !prev_xfer && !prev_abort && !prev_rst && !rst) begin
      if (!valid_out || {opcode_out, operand_out} !== prev_word) mon_viol++;
    end
    if (valid_out && (opcode_out == 8'hFF || !busy)) mon_viol++;

    core_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        core_done   = 1'b1;
        core_result = core_res[done_idx];
        done_idx++;
        if (abort) done_with_abort = 1'b1;
      end
    end

    if (prog_rd_en) begin
      prog_data = mem[prog_addr];
      hold = 1'b1;
      rd_count++;
    end else if (hold) begin
      hold = 1'b0;
    end else begin
      rnd = {$urandom(), $urandom(), $urandom()};
      prog_data = rnd[88:0];
    end

    case (rdy_mode)
      0: core_ready = 1'b1;
      1: core_ready = ($urandom_range(3, 0) != 0);
      default: begin
        if (valid_out && stall_left > 0) begin
          core_ready = 1'b0;
          stall_left--;
        end else begin
          core_ready = 1'b1;
        end
      end
    endcase

    xfer = valid_out && core_ready && !abort && !rst;
    if (xfer) begin
      xfer_q.push_back({opcode_out, operand_out});
      done_cnt = lat;
    end
    prev_valid = valid_out;
    prev_word  = {opcode_out, operand_out};
    prev_xfer  = xfer;
    prev_abort = abort;
    prev_rst   = rst;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    prog_len = PC_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // cyc = clock edges after the start edge until halted or error is seen
  task automatic wait_end(input bit poke, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      start = 1'b0;
      if (halted || error) begin
        ok = 1'b1;
        break;
      end
      if (poke && cyc == 3) start = 1'b1;
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input int len, input bit poke, input int exp_ret,
                           input logic [80:0] exp_last, input int exp_cyc, input int exp_rd);
    int cyc;
    bit ok;
    int bad;
    clear_model();
    pulse_start(len);
    wait_end(poke, cyc, ok);
    chk($sformatf("%s_finished", tag), ok, 1);
    chk($sformatf("%s_halted", tag), {halted, error, busy, valid_out}, 4'b1000);
    chk($sformatf("%s_retired", tag), retired, exp_ret);
    chk($sformatf("%s_last_result", tag), last_result, exp_last);
    chk($sformatf("%s_xfer_count", tag), xfer_q.size(), exp_ret);
    bad = 0;
    for (int i = 0; i < exp_ret; i++)
      if (i >= xfer_q.size() || xfer_q[i] !== mem[i]) bad++;
    chk($sformatf("%s_xfer_order", tag), bad, 0);
    chk($sformatf("%s_rd_count", tag), rd_count, exp_rd);
    chk($sformatf("%s_stability", tag), mon_viol, 0);
    if (exp_cyc >= 0) chk($sformatf("%s_cycles", tag), cyc, exp_cyc);
  endtask

  initial begin
    vec_t v [7];
    int   first_err, n, stopped, l, mode, len, cyc;
    bit   ok;
    logic [80:0] elast;

    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_len = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      core_res[i] = '0;
    end
    repeat (3) tick();
    chk("rst_flags", {busy, halted, error, valid_out, prog_rd_en}, 5'b0);
    chk("rst_counts", {retired, prog_addr}, 16'h0);
    chk("rst_opcode", opcode_out, 0);
    chk("rst_operand", operand_out, 0);
    chk("rst_last_result", last_result, 0);
    rst = 1'b0;
    clear_model();
    chk("idle_flags", {busy, halted, error}, 3'b0);

    v[0] = mk(3, 3, 0, 0, wd(8'h01, 81'd5), wd(8'h01, 81'd7), wd(8'h02, 81'd0), '0,
              81'd5, 81'd7, 81'd12, '0, 3, 81'd12, 21, 3);
    v[1] = mk(4, 3, 0, 0, wd(8'h01, 81'd9), wd(8'hFF, 81'd0), wd(8'h01, 81'd1), wd(8'h01, 81'd2),
              81'h1234, 81'd1, 81'd2, 81'd3, 1, 81'h1234, 9, 2);
    v[2] = mk(1, 1, 0, 0, wd(8'h10, 81'hABC), '0, '0, '0,
              81'd77, '0, '0, '0, 1, 81'd77, 5, 1);
    v[3] = mk(0, 3, 0, 0, '0, '0, '0, '0, '0, '0, '0, '0, 0, 81'd0, 0, 0);
    v[4] = mk(2, 3, 0, 0, wd(8'hFF, 81'd3), wd(8'h01, 81'd4), '0, '0,
              81'd8, 81'd9, '0, '0, 0, 81'd0, 2, 1);
    v[5] = mk(1, 1, 2, 10, wd(8'h03, 81'h42), '0, '0, '0,
              81'd99, '0, '0, '0, 1, 81'd99, 15, 1);
    v[6] = mk(4, 2, 0, 0, wd(8'h01, 81'd1), wd(8'h01, 81'd2), wd(8'h01, 81'd3), wd(8'h02, 81'd4),
              81'd1, 81'd2, 81'd3, 81'd4, 4, 81'd4, 24, 4);

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] = v[k].w[i];
        core_res[i] = v[k].r[i];
      end
      lat = v[k].lat; rdy_mode = v[k].mode; stall_init = v[k].stall;
      run_check($sformatf("vec%0d", k), v[k].len, (k == 0 || k == 6), v[k].exp_ret,
                v[k].exp_last, v[k].exp_cyc, v[k].exp_rd);
    end

    // timeout: core_done withheld, then restart from ERROR
    mem[0] = wd(8'h01, 81'd1); mem[1] = wd(8'h01, 81'd2);
    core_res[0] = 81'h111; core_res[1] = 81'h222;
    lat = 0; rdy_mode = 0;
    clear_model();
    pulse_start(2);
    first_err = -1;
    for (int c = 0; c < 200; c++) begin
      if (error) begin
        first_err = c;
        break;
      end
      tick();
    end
    chk("timeout_cycle", first_err, 66);
    chk("timeout_flags", {error, halted, busy, valid_out, prog_rd_en}, 5'b10000);
    lat = 3;
    clear_model();
    pulse_start(2);
    chk("restart_fetch", {error, busy, prog_rd_en}, 3'b011);
    chk("restart_addr", prog_addr, 0);
    wait_end(1'b0, cyc, ok);
    chk("restart_done", {ok, halted, error}, 3'b110);
    chk("restart_retired", retired, 2);
    chk("restart_last", last_result, 81'h222);

    // abort in the same cycle as core_done on the second instruction
    mem[2] = wd(8'h01, 81'd3);
    core_res[0] = 81'd11; core_res[1] = 81'd22; core_res[2] = 81'd33;
    lat = 3;
    clear_model();
    pulse_start(3);
    for (int c = 0; c < 100 && xfer_q.size() < 2; c++) tick();
    chk("abort_reached", xfer_q.size(), 2);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_coincident", done_with_abort, 1);
    chk("abort_idle", {busy, halted, error, valid_out, prog_rd_en}, 5'b0);
    chk("abort_retired", retired, 1);
    chk("abort_last", last_result, 81'd11);
    repeat (5) tick();
    chk("abort_stays_idle", {busy, halted, error, prog_rd_en}, 4'b0);
    run_check("abort_len0", 0, 1'b0, 0, 81'd0, 0, 0);

    // reset mid-instruction; the late core_done must be ignored
    clear_model();
    pulse_start(3);
    for (int c = 0; c < 100 && xfer_q.size() < 2; c++) tick();
    tick();
    chk("prerst_retired", retired, 1);
    rst = 1'b1;
    #1;
    chk("midrst_state", {busy, valid_out, retired}, 10'h0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("postrst_ignored", {busy, halted, error, retired}, 11'h0);
    chk("postrst_last", last_result, 0);

    // randomized programs against the run-level model
    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(10, 0);
      l = $urandom_range(5, 1);
      mode = $urandom_range(1, 0);
      for (int i = 0; i < 12; i++) begin
        rnd = {$urandom(), $urandom(), $urandom()};
        mem[i] = {($urandom_range(7, 0) == 0) ? 8'hFF : 8'($urandom_range(254, 0)), rnd[80:0]};
        rnd = {$urandom(), $urandom(), $urandom()};
        core_res[i] = rnd[80:0];
      end
      n = 0; stopped = 0;
      for (int i = 0; i < len; i++) begin
        if (mem[i][88:81] == 8'hFF) begin
          stopped = 1;
          break;
        end
        n++;
      end
      elast = (n > 0) ? core_res[n-1] : 81'd0;
      lat = l; rdy_mode = mode; stall_init = 0;
      run_check($sformatf("rand%0d", it), len, it[0], n, elast,
                (mode == 0) ? n * (4 + l) + 2 * stopped : -1, n + stopped);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
